// File: rtl/adder16.sv
// Registered 16-bit two's-complement adder with carry, parity, overflow, zero and sign flags.
// The sum uses four chained 4-bit carry-lookahead blocks, and the flags are taken from the unregistered sum.
module adder16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  output logic [15:0] F,
  output logic        C,
  output logic        P,
  output logic        O,
  output logic        Z,
  output logic        S
);

  // 4-bit lookahead block: returns {carry_out, sum[3:0]}; every carry is flattened from g/p and cin.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  function automatic logic even_parity(input logic [15:0] v);
    return ~^v;
  endfunction

  function automatic logic signed_ovf(input logic signed [15:0] a, input logic signed [15:0] b,
                                      input logic signed [15:0] s);
    return (a[15] & b[15] & ~s[15]) | (~a[15] & ~b[15] & s[15]);
  endfunction

  logic [4:0]  cy;
  logic [15:0] f_d;
  logic [15:0] f_q;
  logic        c_q, p_q, o_q, z_q, s_q;

  assign cy[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_cla
    assign {cy[i+1], f_d[4*i +: 4]} = cla4(X[4*i +: 4], Y[4*i +: 4], cy[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= '0;
      c_q <= 1'b0;
      p_q <= 1'b0;
      o_q <= 1'b0;
      z_q <= 1'b0;
      s_q <= 1'b0;
    end else if (en) begin
      f_q <= f_d;
      c_q <= cy[4];
      p_q <= even_parity(f_d);
      o_q <= signed_ovf(X, Y, f_d);
      z_q <= ~|f_d;
      s_q <= f_d[15];
    end
  end

  assign F = f_q;
  assign C = c_q;
  assign P = p_q;
  assign O = o_q;
  assign Z = z_q;
  assign S = s_q;

endmodule

// File: tb/tb_adder16.sv
// Self-checking bench for adder16: an arithmetic reference model is checked against the DUT on every cycle,
// along with directed literal vectors and randomized operands.
module tb_adder16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [15:0] X   = '0;
  logic [15:0] Y   = '0;
  logic [15:0] F;
  logic        C, P, O, Z, S;

  int checks = 0;
  int errors = 0;

  adder16 dut (
    .clk(clk), .rst(rst), .en(en), .X(X), .Y(Y),
    .F(F), .C(C), .P(P), .O(O), .Z(Z), .S(S)
  );

  always #5 clk = ~clk;

  // Reference state: the packed vector {F,C,P,O,Z,S} that the outputs must hold after each edge.
  logic [20:0] exp_q;
  bit          model_valid = 1'b0;

  function automatic logic [20:0] reference(input logic [15:0] a, input logic [15:0] b);
    int unsigned usum;
    int          ssum;
    logic [15:0] f;
    logic        c, p, o, z, s;
    usum = int'(a) + int'(b);
    f    = usum[15:0];
    c    = (usum >= 65536);
    ssum = int'($signed(a)) + int'($signed(b));
    o    = (ssum > 32767) || (ssum < -32768);
    p    = ($countones(f) % 2) == 0;
    z    = (f == 16'd0);
    s    = (f >= 16'h8000);
    return {f, c, p, o, z, s};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q       = '0;
      model_valid = 1'b1;
    end else if (en) begin
      exp_q = reference(X, Y);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if ({F, C, P, O, Z, S} !== exp_q) begin
        errors++;
        $display("FAIL model t=%0t: got F=%h C=%b P=%b O=%b Z=%b S=%b, expected F=%h C=%b P=%b O=%b Z=%b S=%b",
                 $time, F, C, P, O, Z, S, exp_q[20:5], exp_q[4], exp_q[3], exp_q[2], exp_q[1], exp_q[0]);
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [15:0] a, input logic [15:0] b);
    rst = r;
    en  = e;
    X   = a;
    Y   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [20:0] want);
    checks++;
    if ({F, C, P, O, Z, S} !== want) begin
      errors++;
      $display("FAIL %s: got F=%h C=%b P=%b O=%b Z=%b S=%b, expected F=%h C=%b P=%b O=%b Z=%b S=%b",
               name, F, C, P, O, Z, S, want[20:5], want[4], want[3], want[2], want[1], want[0]);
    end
  endtask

  initial begin
    logic [15:0] a, b;
    logic [15:0] corners [6] = '{16'h0000, 16'hffff, 16'h7fff, 16'h8000, 16'h0001, 16'haaaa};

    // Reset with en=1 and arbitrary operands.
    step(1'b1, 1'b1, 16'h1234, 16'h4321);
    step(1'b1, 1'b1, 16'hffff, 16'h0001);
    check_lit("reset", {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    step(1'b0, 1'b1, 16'h8fff, 16'h8000);
    check_lit("neg_ovf", {16'h0fff, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    step(1'b0, 1'b1, 16'hfffe, 16'h0002);
    check_lit("zero_carry", {16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    step(1'b0, 1'b1, 16'haaaa, 16'h5555);
    check_lit("all_ones", {16'hffff, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    step(1'b0, 1'b1, 16'h7fff, 16'h0001);
    check_lit("pos_ovf", {16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});

    step(1'b0, 1'b1, 16'h0001, 16'h0002);
    check_lit("load_3", {16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    step(1'b0, 1'b0, 16'hffff, 16'hffff);
    check_lit("hold_1", {16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    step(1'b0, 1'b0, 16'h8000, 16'h8000);
    check_lit("hold_2", {16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    step(1'b1, 1'b1, 16'h7fff, 16'h7fff);
    check_lit("rst_prio", {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    step(1'b0, 1'b1, 16'h7fff, 16'h7fff);
    check_lit("after_rst", {16'hfffe, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    step(1'b0, 1'b1, 16'h8000, 16'h8000);
    check_lit("min_plus_min", {16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});

    // Randomized traffic; mixes corner operands, en gaps and rare resets.
    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), a, b);
    end

    step(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
